// File: rtl/clk_ctrl_seq_if.sv
// Console/SAC signal bundle for the power-up and clock-control sequencer.
// No valid/ready pairs here: con_run_h is a level, con_step_h acts on its rising edge, and m_clk_enable_h is a one-cycle completion pulse from the clock generator.
interface clk_ctrl_seq_if;
  logic       con_run_h;
  logic       con_step_h;
  logic       m_clk_enable_h;
  logic       sac_reset_h;
  logic       mseq_init_l;
  logic [1:0] clk_ctrl_h;
  logic       addr_inh_l;
  logic       step_busy_h;
  logic       step_tmo_h;
  logic [7:0] step_cnt_h;

  // master: the sequencer itself; slave: console plus SAC/clock-generator side
  modport master (
    input  con_run_h, con_step_h, m_clk_enable_h,
    output sac_reset_h, mseq_init_l, clk_ctrl_h, addr_inh_l,
    output step_busy_h, step_tmo_h, step_cnt_h
  );

  modport slave (
    output con_run_h, con_step_h, m_clk_enable_h,
    input  sac_reset_h, mseq_init_l, clk_ctrl_h, addr_inh_l,
    input  step_busy_h, step_tmo_h, step_cnt_h
  );
endinterface

// File: rtl/clk_ctrl_seq.sv
// Power-up reset sequencer and run/halt/single-step clock controller for the SAC.
// Runs on the CPU oscillator; every output is registered from the next-state decode.
module clk_ctrl_seq #(
  parameter int RESET_CYC = 16,
  parameter int INIT_CYC  = 8,
  parameter int STEP_TMO  = 255
) (
  input  logic              cpu_osc_in_h,
  input  logic              pwr_reset_h,
  clk_ctrl_seq_if.master    bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    INIT      = 3'd1,
    HALTED    = 3'd2,
    RUN       = 3'd3,
    STEP      = 3'd4,
    STEP_WAIT = 3'd5
  } state_t;

  localparam logic [1:0] CC_RUN  = 2'b00;
  localparam logic [1:0] CC_STOP = 2'b01;
  localparam logic [1:0] CC_STEP = 2'b10;

  // One down-counter is shared by the reset hold, init hold and step timeout phases.
  localparam int MAX_A   = (RESET_CYC > INIT_CYC) ? RESET_CYC : INIT_CYC;
  localparam int MAX_CYC = (MAX_A > STEP_TMO) ? MAX_A : STEP_TMO;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] RESET_LOAD = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] INIT_LOAD  = CW'(INIT_CYC - 1);
  localparam logic [CW-1:0] TMO_LOAD   = CW'(STEP_TMO - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    step_cnt_q, step_cnt_d;
  logic          tmo_q, tmo_d;
  logic          step_q;
  logic          step_edge;

  logic          sac_reset_q, sac_reset_d;
  logic          mseq_init_l_q, mseq_init_l_d;
  logic [1:0]    clk_ctrl_q, clk_ctrl_d;
  logic          addr_inh_l_q, addr_inh_l_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_cnt_d = step_cnt_q;
    tmo_d      = tmo_q;
    step_edge  = bus.con_step_h & ~step_q;

    case (state_q)
      RST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = INIT;
          cnt_d   = INIT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      INIT: begin
        if (cnt_q == '0) state_d = HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      HALTED: begin
        // Run wins over a simultaneous step edge; that edge is simply dropped.
        if (bus.con_run_h) begin
          state_d = RUN;
        end else if (step_edge) begin
          state_d = STEP;
          tmo_d   = 1'b0;
        end
      end
      RUN: begin
        if (!bus.con_run_h) state_d = HALTED;
      end
      STEP: begin
        state_d = STEP_WAIT;
        cnt_d   = TMO_LOAD;
      end
      STEP_WAIT: begin
        // Completion is checked first so an enable on the last cycle is not a timeout.
        if (bus.m_clk_enable_h) begin
          step_cnt_d = step_cnt_q + 8'd1;
          state_d    = HALTED;
        end else if (cnt_q == '0) begin
          tmo_d   = 1'b1;
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = RESET_LOAD;
      end
    endcase

    sac_reset_d   = (state_d == RST_HOLD);
    mseq_init_l_d = !((state_d == RST_HOLD) || (state_d == INIT));
    addr_inh_l_d  = mseq_init_l_d;
    busy_d        = (state_d == STEP) || (state_d == STEP_WAIT);
    clk_ctrl_d    = CC_STOP;
    if (state_d == RUN)  clk_ctrl_d = CC_RUN;
    if (state_d == STEP) clk_ctrl_d = CC_STEP;
  end

  always_ff @(posedge cpu_osc_in_h or posedge pwr_reset_h) begin
    if (pwr_reset_h) begin
      state_q       <= RST_HOLD;
      cnt_q         <= RESET_LOAD;
      step_cnt_q    <= 8'd0;
      tmo_q         <= 1'b0;
      step_q        <= 1'b0;
      sac_reset_q   <= 1'b1;
      mseq_init_l_q <= 1'b0;
      clk_ctrl_q    <= CC_STOP;
      addr_inh_l_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      step_cnt_q    <= step_cnt_d;
      tmo_q         <= tmo_d;
      step_q        <= bus.con_step_h;
      sac_reset_q   <= sac_reset_d;
      mseq_init_l_q <= mseq_init_l_d;
      clk_ctrl_q    <= clk_ctrl_d;
      addr_inh_l_q  <= addr_inh_l_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.sac_reset_h = sac_reset_q;
  assign bus.mseq_init_l = mseq_init_l_q;
  assign bus.clk_ctrl_h  = clk_ctrl_q;
  assign bus.addr_inh_l  = addr_inh_l_q;
  assign bus.step_busy_h = busy_q;
  assign bus.step_tmo_h  = tmo_q;
  assign bus.step_cnt_h  = step_cnt_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_clk_ctrl_seq.sv
// Directed bench for clk_ctrl_seq: power-up timing, single step, timeout, run/step priority, wrap, mid-operation reset.
module tb_clk_ctrl_seq;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_ctrl_seq_if bus();
  logic [2:0] state_dbg;

  clk_ctrl_seq #(
    .RESET_CYC(16),
    .INIT_CYC (8),
    .STEP_TMO (4)
  ) dut (
    .cpu_osc_in_h(clk),
    .pwr_reset_h (rst),
    .bus         (bus),
    .state_dbg   (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_cnt = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Releases reset and checks the 16-cycle sac_reset / 8-cycle mseq_init sequence.
  task automatic power_up_seq(input string tag);
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    check({tag, "_sac_hi_c15"}, 32'(bus.sac_reset_h), 32'd1);
    tick();
    check({tag, "_sac_lo_c16"}, 32'(bus.sac_reset_h), 32'd0);
    check({tag, "_mseq_lo_c16"}, 32'(bus.mseq_init_l), 32'd0);
    for (int i = 1; i <= 7; i++) tick();
    check({tag, "_mseq_lo_c23"}, 32'(bus.mseq_init_l), 32'd0);
    check({tag, "_addr_inh_c23"}, 32'(bus.addr_inh_l), 32'd0);
    tick();
    check({tag, "_mseq_hi_c24"}, 32'(bus.mseq_init_l), 32'd1);
    check({tag, "_addr_inh_c24"}, 32'(bus.addr_inh_l), 32'd1);
    check({tag, "_clk_ctrl_c24"}, 32'(bus.clk_ctrl_h), 32'h1);
    check({tag, "_busy_c24"}, 32'(bus.step_busy_h), 32'd0);
  endtask

  // Asserts reset mid-cycle and checks the reset values appear without a clock edge.
  task automatic reset_now(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_sac"}, 32'(bus.sac_reset_h), 32'd1);
    check({tag, "_mseq"}, 32'(bus.mseq_init_l), 32'd0);
    check({tag, "_busy"}, 32'(bus.step_busy_h), 32'd0);
    check({tag, "_clk_ctrl"}, 32'(bus.clk_ctrl_h), 32'h1);
    check({tag, "_addr_inh"}, 32'(bus.addr_inh_l), 32'd0);
    check({tag, "_cnt"}, 32'(bus.step_cnt_h), 32'd0);
    check({tag, "_tmo"}, 32'(bus.step_tmo_h), 32'd0);
    model_cnt = 8'd0;
  endtask

  // Issues one step; m_clk_enable_h is raised in STEP_WAIT cycle 'delay' (1..4).
  task automatic do_step(input string tag, input int delay);
    bus.con_step_h = 1'b1;
    tick();
    bus.con_step_h = 1'b0;
    for (int i = 1; i <= delay; i++) begin
      tick();
      if (i == delay) bus.m_clk_enable_h = 1'b1;
    end
    tick();
    bus.m_clk_enable_h = 1'b0;
    model_cnt = model_cnt + 8'd1;
    exp_q.push_back(model_cnt);
    check({tag, "_cnt"}, 32'(bus.step_cnt_h), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.con_run_h      = 1'b0;
    bus.con_step_h     = 1'b0;
    bus.m_clk_enable_h = 1'b0;
    rst                = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("rst_sac", 32'(bus.sac_reset_h), 32'd1);
    check("rst_mseq", 32'(bus.mseq_init_l), 32'd0);
    check("rst_clk_ctrl", 32'(bus.clk_ctrl_h), 32'h1);
    check("rst_addr_inh", 32'(bus.addr_inh_l), 32'd0);
    check("rst_busy", 32'(bus.step_busy_h), 32'd0);
    check("rst_tmo", 32'(bus.step_tmo_h), 32'd0);
    check("rst_cnt", 32'(bus.step_cnt_h), 32'd0);

    power_up_seq("pwrup");

    // single step, enable three cycles after STEP
    bus.con_step_h = 1'b1;
    tick();
    bus.con_step_h = 1'b0;
    check("step_clk_step", 32'(bus.clk_ctrl_h), 32'h2);
    check("step_busy_c1", 32'(bus.step_busy_h), 32'd1);
    tick();
    check("step_clk_stop", 32'(bus.clk_ctrl_h), 32'h1);
    check("step_busy_c2", 32'(bus.step_busy_h), 32'd1);
    tick();
    check("step_busy_c3", 32'(bus.step_busy_h), 32'd1);
    tick();
    check("step_busy_c4", 32'(bus.step_busy_h), 32'd1);
    check("step_cnt_pre", 32'(bus.step_cnt_h), 32'd0);
    bus.m_clk_enable_h = 1'b1;
    tick();
    bus.m_clk_enable_h = 1'b0;
    model_cnt = 8'd1;
    check("step_busy_done", 32'(bus.step_busy_h), 32'd0);
    check("step_cnt_1", 32'(bus.step_cnt_h), 32'd1);
    check("step_tmo_none", 32'(bus.step_tmo_h), 32'd0);

    // timeout: no enable, four STEP_WAIT cycles
    bus.con_step_h = 1'b1;
    tick();
    bus.con_step_h = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("tmo_wait_busy", 32'(bus.step_busy_h), 32'd1);
      check("tmo_wait_flag", 32'(bus.step_tmo_h), 32'd0);
    end
    tick();
    check("tmo_flag", 32'(bus.step_tmo_h), 32'd1);
    check("tmo_busy", 32'(bus.step_busy_h), 32'd0);
    check("tmo_cnt", 32'(bus.step_cnt_h), 32'(model_cnt));
    tick();
    check("tmo_sticky", 32'(bus.step_tmo_h), 32'd1);

    // next step clears the flag; enable on the last timeout cycle counts as completion
    bus.con_step_h = 1'b1;
    tick();
    bus.con_step_h = 1'b0;
    check("tmo_clear", 32'(bus.step_tmo_h), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) bus.m_clk_enable_h = 1'b1;
    end
    tick();
    bus.m_clk_enable_h = 1'b0;
    model_cnt = model_cnt + 8'd1;
    check("edge_tmo_flag", 32'(bus.step_tmo_h), 32'd0);
    check("edge_cnt", 32'(bus.step_cnt_h), 32'(model_cnt));

    // step edge while busy is ignored
    bus.con_step_h = 1'b1;
    tick();
    bus.con_step_h = 1'b0;
    tick();
    bus.con_step_h = 1'b1;
    tick();
    bus.con_step_h = 1'b0;
    bus.m_clk_enable_h = 1'b1;
    tick();
    bus.m_clk_enable_h = 1'b0;
    model_cnt = model_cnt + 8'd1;
    check("busy_edge_cnt", 32'(bus.step_cnt_h), 32'(model_cnt));
    tick();
    check("busy_edge_no_step", 32'(bus.step_busy_h), 32'd0);
    check("busy_edge_clk", 32'(bus.clk_ctrl_h), 32'h1);

    // run beats a simultaneous step edge
    bus.con_run_h  = 1'b1;
    bus.con_step_h = 1'b1;
    tick();
    check("prio_clk_run", 32'(bus.clk_ctrl_h), 32'h0);
    check("prio_busy", 32'(bus.step_busy_h), 32'd0);
    tick();
    bus.con_run_h = 1'b0;
    tick();
    check("prio_halt_clk", 32'(bus.clk_ctrl_h), 32'h1);
    tick();
    check("prio_no_step", 32'(bus.step_busy_h), 32'd0);
    check("prio_cnt", 32'(bus.step_cnt_h), 32'(model_cnt));
    bus.con_step_h = 1'b0;
    tick();

    // step edges ignored while running
    bus.con_run_h = 1'b1;
    tick();
    bus.con_step_h = 1'b1;
    tick();
    bus.con_step_h = 1'b0;
    tick();
    check("run_ign_busy", 32'(bus.step_busy_h), 32'd0);
    check("run_ign_clk", 32'(bus.clk_ctrl_h), 32'h0);
    bus.con_run_h = 1'b0;
    tick();
    check("run_halt_clk", 32'(bus.clk_ctrl_h), 32'h1);

    // run during a step is deferred until the step finishes
    bus.con_step_h = 1'b1;
    tick();
    bus.con_step_h = 1'b0;
    bus.con_run_h  = 1'b1;
    tick();
    check("defer_clk_stop", 32'(bus.clk_ctrl_h), 32'h1);
    check("defer_busy", 32'(bus.step_busy_h), 32'd1);
    bus.m_clk_enable_h = 1'b1;
    tick();
    bus.m_clk_enable_h = 1'b0;
    model_cnt = model_cnt + 8'd1;
    check("defer_halted_clk", 32'(bus.clk_ctrl_h), 32'h1);
    check("defer_cnt", 32'(bus.step_cnt_h), 32'(model_cnt));
    tick();
    check("defer_run_clk", 32'(bus.clk_ctrl_h), 32'h0);
    bus.con_run_h = 1'b0;
    tick();

    // wrap the step counter back to zero
    while (model_cnt != 8'd0) do_step("wrap", 1);
    check("wrap_zero", 32'(bus.step_cnt_h), 32'd0);

    // reset in STEP_WAIT
    do_step("pre_rst", 2);
    bus.con_step_h = 1'b1;
    tick();
    bus.con_step_h = 1'b0;
    tick();
    reset_now("rst_sw");
    tick();
    power_up_seq("rst_sw_pwr");

    // reset in INIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("init_sac_lo", 32'(bus.sac_reset_h), 32'd0);
    check("init_mseq_lo", 32'(bus.mseq_init_l), 32'd0);
    reset_now("rst_init");
    tick();
    power_up_seq("rst_init_pwr");
    do_step("post_rst", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
